ram_bist_ctrl: RTL

//  Synthesizable initiator for the 32x8 single-port RAM interface (addr, data_in, wr_rd, data_out).
//  On start, writes an address-derived pattern to every location, reads all locations back,
//  and compares each read against the expected value. Reports pass/fail, error count and first failing address.

---
 rtl/ram_bist_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: self-test sequencer for a single-port RAM.
// Writes SEED^addr to every location, reads every location back, compares each
// read against the expected pattern and reports pass/fail, the number of
// mismatching locations and the first failing address.
module ram_bist_ctrl #(
  parameter int                 ADDR_W = 5,
  parameter int                 DATA_W = 8,
  parameter logic [DATA_W-1:0]  SEED   = 8'hA5,
  parameter int                 RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] ADDR_LAST  = {ADDR_W{1'b1}};
  // DRAIN lasts RD_LAT+1 cycles so the last compare has landed in err_count
  // before pass is derived from it.
  localparam logic [2:0]        DRAIN_LAST = 3'(RD_LAT);

  // Expected data for a location: SEED xor the zero-extended address.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    logic [DATA_W+ADDR_W-1:0] ext;
    ext = {{DATA_W{1'b0}}, a};
    return SEED ^ ext[DATA_W-1:0];
  endfunction

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_rd_q, wr_rd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ADDR_W:0]   err_q, err_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic [2:0]        drain_q, drain_d;

  // Compare pipeline: one stage per cycle of RAM read latency.
  logic              pipe_vld_q  [RD_LAT];
  logic [DATA_W-1:0] pipe_exp_q  [RD_LAT];
  logic [ADDR_W-1:0] pipe_addr_q [RD_LAT];

  logic              mismatch_s;

  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_wr_rd      = wr_rd_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;

  assign mismatch_s = pipe_vld_q[RD_LAT-1] && (mem_rdata != pipe_exp_q[RD_LAT-1]);

  // Next-state logic for the sequencer, RAM drive and result registers.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_rd_d = wr_rd_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    first_d = first_q;
    drain_d = drain_q;

    if (mismatch_s) begin
      err_d = err_q + {{ADDR_W{1'b0}}, 1'b1};
      if (err_q == {(ADDR_W+1){1'b0}}) begin
        first_d = pipe_addr_q[RD_LAT-1];
      end else begin
        first_d = first_q;
      end
    end else begin
      err_d = err_q;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_WRITE;
          addr_d  = {ADDR_W{1'b0}};
          wdata_d = SEED;
          wr_rd_d = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = {(ADDR_W+1){1'b0}};
          first_d = {ADDR_W{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      ST_WRITE: begin
        if (addr_q == ADDR_LAST) begin
          state_d = ST_READ;
          addr_d  = {ADDR_W{1'b0}};
          wdata_d = {DATA_W{1'b0}};
          wr_rd_d = 1'b0;
        end else begin
          addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          wdata_d = pattern(addr_q + {{(ADDR_W-1){1'b0}}, 1'b1});
        end
      end
      ST_READ: begin
        if (addr_q == ADDR_LAST) begin
          state_d = ST_DRAIN;
          addr_d  = {ADDR_W{1'b0}};
          drain_d = 3'd0;
        end else begin
          addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_q == {(ADDR_W+1){1'b0}});
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        addr_d  = {ADDR_W{1'b0}};
        wdata_d = {DATA_W{1'b0}};
        wr_rd_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      wr_rd_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= {(ADDR_W+1){1'b0}};
      first_q <= {ADDR_W{1'b0}};
      drain_q <= 3'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_rd_q <= wr_rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      first_q <= first_d;
      drain_q <= drain_d;
    end
  end

  // Carry {valid, expected, address} of each issued read until its data returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld_q[i]  <= 1'b0;
        pipe_exp_q[i]  <= {DATA_W{1'b0}};
        pipe_addr_q[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      pipe_vld_q[0]  <= (state_q == ST_READ);
      pipe_exp_q[0]  <= pattern(addr_q);
      pipe_addr_q[0] <= addr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_exp_q[i]  <= pipe_exp_q[i-1];
        pipe_addr_q[i] <= pipe_addr_q[i-1];
      end
    end
  end

endmodule
